// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit.
// Sequences fetch/decode/execute for a single-issue datapath. It drives the
// datapath select lines, runs the instruction- and data-memory handshakes,
// traps on unsupported encodings and counts retired instructions.
//
// Handshake: a request is raised on entry to FETCH, MEM_RD or MEM_WR and is
// held every cycle until the matching ack is seen high. The transfer completes
// on the rising edge that ends the ack cycle. Acks seen in any other state are
// ignored.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst,
  input  logic             zero,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             IRWrite,
  output logic             ALUSrc_A,
  output logic             ALUSrc_B,
  output logic [2:0]       ALU_Control,
  output logic [1:0]       Branch,
  output logic [1:0]       DatatoReg,
  output logic [1:0]       RegDst,
  output logic             RegWrite,
  output logic             PCEN,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEM_RD = 4'd4,
    S_MEM_WR = 4'd5,
    S_BRANCH = 4'd6,
    S_JUMP   = 4'd7,
    S_TRAP   = 4'd8
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  state_t     cur;
  state_t     dec_next;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       r_valid;
  logic [2:0] r_alu;
  logic       unused_inst_bits;

  assign opcode           = inst[31:26];
  assign funct            = inst[5:0];
  assign unused_inst_bits = ^inst[25:6];
  assign state            = cur;

  // Classify the held instruction: R-type ALU op code and decode target state.
  always_comb begin
    r_valid  = 1'b1;
    r_alu    = ALU_AND;
    dec_next = S_TRAP;
    case (funct)
      FN_ADD:  r_alu = ALU_ADD;
      FN_SUB:  r_alu = ALU_SUB;
      FN_AND:  r_alu = ALU_AND;
      FN_OR:   r_alu = ALU_OR;
      FN_NOR:  r_alu = ALU_NOR;
      FN_SLT:  r_alu = ALU_SLT;
      FN_SRL:  r_alu = ALU_SRL;
      default: r_valid = 1'b0;
    endcase
    case (opcode)
      OP_R: begin
        if (r_valid)              dec_next = S_EXEC;
        else if (funct == FN_JR)  dec_next = S_JUMP;
        else                      dec_next = S_TRAP;
      end
      OP_ADDI, OP_SLTI, OP_LUI:   dec_next = S_EXEC;
      OP_LW:                      dec_next = S_MEM_RD;
      OP_SW:                      dec_next = S_MEM_WR;
      OP_BEQ, OP_BNE:             dec_next = S_BRANCH;
      OP_J, OP_JAL:               dec_next = S_JUMP;
      default:                    dec_next = S_TRAP;
    endcase
  end

  // State register; TRAP is terminal until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur <= S_IDLE;
    end else begin
      case (cur)
        S_IDLE:   cur <= S_FETCH;
        S_FETCH:  if (imem_ack) cur <= S_DECODE;
        S_DECODE: cur <= dec_next;
        S_EXEC, S_BRANCH, S_JUMP: cur <= S_FETCH;
        S_MEM_RD, S_MEM_WR: if (dmem_ack) cur <= S_FETCH;
        S_TRAP:   cur <= S_TRAP;
        default:  cur <= S_IDLE;
      endcase
    end
  end

  // Datapath controls decoded from state; acks and zero act in the same cycle.
  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    IRWrite     = 1'b0;
    ALUSrc_A    = 1'b0;
    ALUSrc_B    = 1'b0;
    ALU_Control = ALU_AND;
    Branch      = 2'b00;
    DatatoReg   = 2'b00;
    RegDst      = 2'b00;
    RegWrite    = 1'b0;
    PCEN        = 1'b0;
    illegal     = 1'b0;
    case (cur)
      S_FETCH: begin
        imem_req = 1'b1;
        IRWrite  = imem_ack;
      end
      S_EXEC: begin
        RegWrite = 1'b1;
        PCEN     = 1'b1;
        if (opcode == OP_R) begin
          RegDst      = 2'b01;
          ALU_Control = r_alu;
          ALUSrc_A    = (funct == FN_SRL);
        end else if (opcode == OP_ADDI) begin
          ALUSrc_B    = 1'b1;
          ALU_Control = ALU_ADD;
        end else if (opcode == OP_SLTI) begin
          ALUSrc_B    = 1'b1;
          ALU_Control = ALU_SLT;
        end else begin
          DatatoReg   = 2'b10;
        end
      end
      S_MEM_RD: begin
        dmem_req    = 1'b1;
        ALUSrc_B    = 1'b1;
        ALU_Control = ALU_ADD;
        if (dmem_ack) begin
          RegWrite  = 1'b1;
          DatatoReg = 2'b01;
          PCEN      = 1'b1;
        end
      end
      S_MEM_WR: begin
        dmem_req    = 1'b1;
        dmem_we     = 1'b1;
        ALUSrc_B    = 1'b1;
        ALU_Control = ALU_ADD;
        PCEN        = dmem_ack;
      end
      S_BRANCH: begin
        ALU_Control = ALU_SUB;
        PCEN        = 1'b1;
        if ((opcode == OP_BEQ && zero) || (opcode == OP_BNE && !zero))
          Branch = 2'b01;
      end
      S_JUMP: begin
        PCEN = 1'b1;
        if (opcode == OP_R) begin
          Branch = 2'b11;
        end else begin
          Branch = 2'b10;
          if (opcode == OP_JAL) begin
            RegWrite  = 1'b1;
            RegDst    = 2'b10;
            DatatoReg = 2'b11;
          end
        end
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

  // Retired-instruction counter: one step per PC update, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      retired <= '0;
    else if (PCEN) retired <= retired + CNT_W'(1);
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl with a mnemonic-level reference model.
// A 4-bit counter instance is used so counter wrap is reached naturally.
module tb_mc_ctrl;

  localparam int CNT_W = 4;
  localparam int RW    = 18;

  logic              clk;
  logic              rst;
  logic [31:0]       inst;
  logic              zero;
  logic              imem_req, imem_ack;
  logic              dmem_req, dmem_we, dmem_ack;
  logic              IRWrite, ALUSrc_A, ALUSrc_B;
  logic [2:0]        ALU_Control;
  logic [1:0]        Branch, DatatoReg, RegDst;
  logic              RegWrite, PCEN, illegal;
  logic [3:0]        state;
  logic [CNT_W-1:0]  retired;
  logic [25:0]       all_out;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [RW-1:0] exp_q[$];

  string mn_list [17] = '{"add", "sub", "and", "or", "nor", "slt", "srl",
                          "addi", "slti", "lui", "lw", "sw", "beq", "bne",
                          "j", "jal", "jr"};

  mc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .inst(inst), .zero(zero),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .IRWrite(IRWrite), .ALUSrc_A(ALUSrc_A), .ALUSrc_B(ALUSrc_B),
    .ALU_Control(ALU_Control), .Branch(Branch), .DatatoReg(DatatoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .PCEN(PCEN),
    .illegal(illegal), .state(state), .retired(retired)
  );

  assign all_out = {imem_req, dmem_req, dmem_we, IRWrite, ALUSrc_A, ALUSrc_B,
                    ALU_Control, Branch, DatatoReg, RegDst, RegWrite, PCEN,
                    illegal, state, retired};

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instruction -> mnemonic -> final-cycle control set
  function automatic string mnem(input logic [31:0] ins);
    case (ins[31:26])
      6'b000000: case (ins[5:0])
        6'b100000: return "add";
        6'b100010: return "sub";
        6'b100100: return "and";
        6'b100101: return "or";
        6'b100111: return "nor";
        6'b101010: return "slt";
        6'b000010: return "srl";
        6'b001000: return "jr";
        default:   return "ill";
      endcase
      6'b001000: return "addi";
      6'b001010: return "slti";
      6'b001111: return "lui";
      6'b100011: return "lw";
      6'b101011: return "sw";
      6'b000100: return "beq";
      6'b000101: return "bne";
      6'b000010: return "j";
      6'b000011: return "jal";
      default:   return "ill";
    endcase
  endfunction

  function automatic logic [31:0] make_instr(input string m);
    logic [31:0] r;
    r = $urandom();
    case (m)
      "add":  return {6'b000000, r[25:6], 6'b100000};
      "sub":  return {6'b000000, r[25:6], 6'b100010};
      "and":  return {6'b000000, r[25:6], 6'b100100};
      "or":   return {6'b000000, r[25:6], 6'b100101};
      "nor":  return {6'b000000, r[25:6], 6'b100111};
      "slt":  return {6'b000000, r[25:6], 6'b101010};
      "srl":  return {6'b000000, r[25:6], 6'b000010};
      "jr":   return {6'b000000, r[25:6], 6'b001000};
      "addi": return {6'b001000, r[25:0]};
      "slti": return {6'b001010, r[25:0]};
      "lui":  return {6'b001111, r[25:0]};
      "lw":   return {6'b100011, r[25:0]};
      "sw":   return {6'b101011, r[25:0]};
      "beq":  return {6'b000100, r[25:0]};
      "bne":  return {6'b000101, r[25:0]};
      "j":    return {6'b000010, r[25:0]};
      "jal":  return {6'b000011, r[25:0]};
      default: return {6'b111111, r[25:0]};
    endcase
  endfunction

  // Record layout: Branch, RegDst, DatatoReg, RegWrite, ALUSrc_A, ALUSrc_B,
  // ALU_Control, dmem_req, dmem_we, retired-before-increment
  function automatic logic [RW-1:0] model_retire(input logic [31:0] ins, input logic z, input int cnt);
    logic [1:0] br = 2'b00, rd = 2'b00, dr = 2'b00;
    logic rw = 1'b0, sa = 1'b0, sb = 1'b0, dq = 1'b0, dw = 1'b0;
    logic [2:0] alu = 3'b000;
    case (mnem(ins))
      "add":  begin rw = 1; rd = 2'b01; alu = 3'b010; end
      "sub":  begin rw = 1; rd = 2'b01; alu = 3'b110; end
      "and":  begin rw = 1; rd = 2'b01; alu = 3'b000; end
      "or":   begin rw = 1; rd = 2'b01; alu = 3'b001; end
      "nor":  begin rw = 1; rd = 2'b01; alu = 3'b100; end
      "slt":  begin rw = 1; rd = 2'b01; alu = 3'b111; end
      "srl":  begin rw = 1; rd = 2'b01; alu = 3'b101; sa = 1; end
      "addi": begin rw = 1; sb = 1; alu = 3'b010; end
      "slti": begin rw = 1; sb = 1; alu = 3'b111; end
      "lui":  begin rw = 1; dr = 2'b10; end
      "lw":   begin rw = 1; dr = 2'b01; sb = 1; alu = 3'b010; dq = 1; end
      "sw":   begin sb = 1; alu = 3'b010; dq = 1; dw = 1; end
      "beq":  begin alu = 3'b110; br = z ? 2'b01 : 2'b00; end
      "bne":  begin alu = 3'b110; br = z ? 2'b00 : 2'b01; end
      "j":    br = 2'b10;
      "jal":  begin br = 2'b10; rw = 1; rd = 2'b10; dr = 2'b11; end
      "jr":   br = 2'b11;
      default: ;
    endcase
    return {br, rd, dr, rw, sa, sb, alu, dq, dw, 4'(cnt)};
  endfunction

  // Scoreboard monitor: every PC update must match the oldest expectation
  always @(negedge clk) begin
    logic [RW-1:0] e;
    if (rst && PCEN) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pcen", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("retire", {14'd0, Branch, RegDst, DatatoReg, RegWrite, ALUSrc_A,
                         ALUSrc_B, ALU_Control, dmem_req, dmem_we, retired},
              {14'd0, e});
      end
    end
  end

  // Driver: wait for fetch request, spraying ignored dmem acks meanwhile
  task automatic wait_imem_req();
    int n = 0;
    while (!imem_req && n < 50) begin
      dmem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    if (n == 50) check("imem_req_timeout", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic run_instr(input string m, input logic z, input int idly, input int ddly);
    logic [31:0] ins;
    int dcount;
    ins = make_instr(m);
    exp_q.push_back(model_retire(ins, z, exp_cnt));
    exp_cnt = (exp_cnt + 1) & 15;
    wait_imem_req();
    repeat (idly) begin
      imem_ack = 1'b0;
      dmem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
    imem_ack = 1'b1;
    inst = ins;
    zero = z;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    if (m == "lw" || m == "sw") begin
      @(posedge clk); #1;
      dcount = 0;
      repeat (ddly) begin
        dmem_ack = 1'b0;
        imem_ack = 1'($urandom_range(0, 1));
        #1;
        if (dmem_req) dcount++;
        check("mem_wait", {28'd0, dmem_req, dmem_we, PCEN, RegWrite},
              {28'd0, 1'b1, (m == "sw"), 2'b00});
        @(posedge clk); #1;
      end
      imem_ack = 1'b0;
      dmem_ack = 1'b1;
      #1;
      if (dmem_req) dcount++;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      check("dmem_req_cycles", 32'(dcount), 32'(ddly + 1));
    end
  endtask

  task automatic do_trap(input logic [31:0] ins);
    wait_imem_req();
    dmem_ack = 1'b0;
    imem_ack = 1'b1;
    inst = ins;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    check("trap_decode", {28'd0, state}, 32'd2);
    @(posedge clk); #1;
    check("trap_enter", {27'd0, illegal, state}, {27'd0, 1'b1, 4'd8});
    repeat (10) begin
      imem_ack = 1'($urandom_range(0, 1));
      dmem_ack = 1'($urandom_range(0, 1));
      #1;
      check("trap_hold", {21'd0, imem_req, dmem_req, PCEN, illegal, state, retired},
            {21'd0, 3'b000, 1'b1, 4'd8, 4'(exp_cnt)});
      @(posedge clk); #1;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  // Main stimulus
  initial begin
    logic [31:0] add_ins;
    rst = 1'b1; inst = '0; zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #2 rst = 1'b0;
    #1 check("reset_async", {6'd0, all_out}, 32'd0);
    repeat (2) @(posedge clk);
    #1 check("reset_hold", {6'd0, all_out}, 32'd0);

    // add with imem_ack held high from reset release
    add_ins = make_instr("add");
    inst = add_ins;
    imem_ack = 1'b1;
    exp_q.push_back(model_retire(add_ins, 1'b0, 0));
    exp_cnt = 1;
    @(posedge clk); #1 rst = 1'b1;
    #1 check("seq_idle", {27'd0, imem_req, state}, {27'd0, 1'b0, 4'd0});
    @(posedge clk); #1 check("seq_fetch", {27'd0, IRWrite, state}, {27'd0, 1'b1, 4'd1});
    @(posedge clk); #1 check("seq_decode", {28'd0, state}, 32'd2);
    @(posedge clk); #1 check("seq_exec", {28'd0, state}, 32'd3);
    imem_ack = 1'b0;
    @(posedge clk); #1 check("seq_refetch", {24'd0, state, retired}, {24'd0, 4'd1, 4'd1});

    // Directed cases
    run_instr("lw", 1'b0, 0, 3);
    run_instr("beq", 1'b1, 1, 0);
    run_instr("beq", 1'b0, 0, 0);
    run_instr("jal", 1'b0, 2, 0);
    run_instr("jr", 1'b0, 0, 0);
    run_instr("sw", 1'b0, 0, 0);
    run_instr("srl", 1'b0, 0, 0);
    run_instr("lui", 1'b1, 0, 0);

    // Randomized mix
    for (int i = 0; i < 150; i++)
      run_instr(mn_list[$urandom_range(0, 16)], 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 4));

    // Bring the counter to all-ones, then a store must wrap it
    while (exp_cnt != 15)
      run_instr(mn_list[$urandom_range(0, 16)], 1'($urandom_range(0, 1)), 0, 1);
    run_instr("sw", 1'b0, 1, 2);
    check("wrap", {28'd0, retired}, 32'd0);

    // Unsupported opcode traps
    do_trap({6'b111111, 26'($urandom())});

    // Reset out of TRAP, then reset in the middle of a fetch
    rst = 1'b0;
    #1 check("reset_in_trap", {6'd0, all_out}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    exp_cnt = 0;
    #1 check("idle_no_req", {27'd0, imem_req, state}, {27'd0, 1'b0, 4'd0});
    @(posedge clk); #1 check("first_req", {27'd0, imem_req, state}, {27'd0, 1'b1, 4'd1});
    #2 rst = 1'b0;
    #1 check("reset_mid_fetch", {6'd0, all_out}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    for (int i = 0; i < 12; i++)
      run_instr(mn_list[$urandom_range(0, 16)], 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 3));

    // Unsupported R-type funct traps too
    do_trap({6'b000000, 20'($urandom()), 6'b111111});

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
